// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, freeze and exception-redirect controller for the 5-stage pipeline
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic       idex_mem_r,
    input  logic [4:0] idex_rd_addr,
    input  logic       ex_branch_taken,
    input  logic       ex_syscall,
    input  logic       ex_eret,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       cu_stall,
    output logic       cu_flush,
    output logic       exmem_stall,
    output logic       exmem_flush,
    output logic [1:0] pc_sel,
    output logic       exc_valid,
    output logic [1:0] exc_code,
    output logic       mem_abort
);

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] EXC = 1'b1;

    localparam logic [CW-1:0] WCNT_LIMIT = CW'(MEM_TIMEOUT);

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_VECTOR = 2'd2;
    localparam logic [1:0] PC_EPC    = 2'd3;

    logic [0:0]    state, state_next;
    logic [CW-1:0] wcnt, wcnt_next;
    logic          mem_wait;
    logic          timeout;
    logic          load_use;

    assign mem_wait = mem_req & ~mem_ready;
    assign timeout  = (state == RUN) & mem_wait & (wcnt == WCNT_LIMIT);
    assign load_use = idex_mem_r & (idex_rd_addr != 5'd0) &
                      ((idex_rd_addr == id_rs_addr) |
                       (id_uses_rt & (idex_rd_addr == id_rt_addr)));

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        cu_stall    = 1'b0;
        cu_flush    = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = PC_SEQ;
        exc_valid   = 1'b0;
        exc_code    = 2'd0;
        mem_abort   = 1'b0;
        state_next  = RUN;
        wcnt_next   = '0;

        if (reset) begin
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == EXC) begin
            // Second flush cycle after a redirect; hazard inputs belong to squashed work.
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
        end else if (timeout) begin
            mem_abort   = 1'b1;
            exc_valid   = 1'b1;
            exc_code    = 2'd2;
            pc_sel      = PC_VECTOR;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
            state_next  = EXC;
        end else if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            cu_stall    = 1'b1;
            exmem_stall = 1'b1;
            wcnt_next   = wcnt + CW'(1);
        end else if (ex_syscall) begin
            exc_valid   = 1'b1;
            exc_code    = 2'd1;
            pc_sel      = PC_VECTOR;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
            state_next  = EXC;
        end else if (ex_eret) begin
            pc_sel      = PC_EPC;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            exmem_flush = 1'b1;
            state_next  = EXC;
        end else if (ex_branch_taken) begin
            // A taken branch squashes the dependent instruction, so no load-use stall is needed.
            pc_sel      = PC_BRANCH;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            cu_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and flow controller for the five-stage MIPS pipeline. It produces the per-stage stall, flush and PC-select controls that sequence the IF/ID, ID/EX and EX/MEM pipeline registers. It covers load-use bubbles, taken-branch squashes, data-memory wait freezes with a timeout watchdog, and the syscall/eret/bus-error redirect. It sits beside the control unit; its `cu_stall`/`cu_flush` drive the ID/EX register directly.

## Interface
Parameters:
- MEM_TIMEOUT, 16: wait cycles tolerated on a data-memory request before bus-error abort (≥2).
- CW, 5: width of the wait counter; must satisfy 2^CW > MEM_TIMEOUT.

Ports (clock and reset first):
- clk  in  1  single clock. State updates on posedge; pipeline registers sample on negedge.
- reset  in  1  asynchronous, active-high.
- id_rs_addr  in  5  rs of the instruction in ID.
- id_rt_addr  in  5  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- idex_mem_r  in  1  instruction in EX is a load.
- idex_rd_addr  in  5  destination of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_syscall  in  1  syscall in EX.
- ex_eret  in  1  eret in EX.
- mem_req  in  1  MEM stage has an active data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID.
- cu_stall  out  1  hold ID/EX.
- cu_flush  out  1  clear ID/EX; ignored by the register when cu_stall=1.
- exmem_stall  out  1  hold EX/MEM.
- exmem_flush  out  1  clear EX/MEM.
- pc_sel  out  2  next-PC source: 0 sequential, 1 branch target, 2 exception vector, 3 EPC.
- exc_valid  out  1  one-cycle pulse: CP0 records EPC/cause.
- exc_code  out  2  cause: 0 none, 1 syscall, 2 bus timeout. Valid with exc_valid.
- mem_abort  out  1  one-cycle pulse: drop the pending memory access.

## Operation
- FSM states are RUN and EXC. The wait counter `wcnt[CW-1:0]` is registered.
- Outputs are combinational from state, wcnt and inputs. When conditions overlap, priority is: reset > EXC state > timeout > mem freeze > exception/eret > branch > load-use.
- **Reset asserted:** state=RUN, wcnt=0. All stalls=0, all flushes=1, pc_sel=0, exc_valid=0, exc_code=0, mem_abort=0.
- **EXC state:** lasts exactly one cycle and then returns to RUN.
  - ifid_flush=cu_flush=exmem_flush=1, stalls=0, pc_sel=0.
  - All hazard inputs are ignored.
- **Timeout** (RUN, mem_req & !mem_ready & wcnt==MEM_TIMEOUT):
  - mem_abort=1, exc_valid=1, exc_code=2, pc_sel=2.
  - Three flushes=1, stalls=0.
  - Next state is EXC and wcnt clears.
- **Mem freeze** (mem_req & !mem_ready, no timeout):
  - pc_stall=ifid_stall=cu_stall=exmem_stall=1.
  - All flushes=0, pc_sel=0.
  - wcnt increments.
- **wcnt clear:** wcnt clears in any cycle where !mem_req or mem_ready.
- **Syscall** (RUN, no freeze): exc_valid=1, exc_code=1, pc_sel=2, three flushes=1, next state EXC.
- **Eret** (RUN, no freeze): pc_sel=3, three flushes=1, exc_valid=0, next state EXC.
- **ex_syscall and ex_eret both high:** syscall wins.
- **Branch taken:** pc_sel=1, ifid_flush=1, cu_flush=1, exmem_flush=0, no stalls.
- **Load-use:** the hazard is idex_mem_r & idex_rd_addr≠0 & (idex_rd_addr==id_rs_addr | (id_uses_rt & idex_rd_addr==id_rt_addr)).
  - Response: pc_stall=ifid_stall=1, cu_flush=1 (bubble), cu_stall=0.
- **Branch and load-use together:** the branch wins and no stall is issued.
- **Default:** all outputs 0.

## Timing
- Hazard responses are zero-latency: decided in the same cycle the inputs appear, and settled before the negedge sample.
- A freeze lasts exactly as long as mem_req & !mem_ready, up to MEM_TIMEOUT cycles.
  - Timeout fires on wait cycle MEM_TIMEOUT+1.
  - mem_ready arriving in the same cycle as the timeout condition is impossible by definition; ready always wins.
- After an exception or eret, the flushes hold for 2 cycles (trigger cycle + EXC). pc_sel≠0 only in the trigger cycle.
- An exception input during EXC is dropped.
- Reset mid-freeze or mid-EXC returns to RUN immediately, with wcnt=0 asynchronously.

## Test plan
- **Load-use:** idex_mem_r=1, idex_rd_addr=8, id_rs_addr=8 -> pc_stall=ifid_stall=1, cu_flush=1, cu_stall=0 for 1 cycle. Repeat with idex_rd_addr=0 -> no stall.
- **Branch over load-use:** ex_branch_taken=1 with a load-use hazard present -> pc_sel=1, ifid_flush=cu_flush=1, pc_stall=0.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles, then ready -> all four stalls high for exactly 3 cycles, wcnt returns to 0, no abort.
- **Timeout:** MEM_TIMEOUT=4, mem_ready held 0 -> stalls for 4 cycles; on cycle 5 mem_abort=1, exc_valid=1, exc_code=2, pc_sel=2; next cycle EXC with flushes=1, pc_sel=0.
- **Syscall and eret:** ex_syscall=1 -> exc_valid=1, exc_code=1, pc_sel=2, flushes for 2 cycles. ex_eret=1 -> pc_sel=3, exc_valid=0. Both high -> syscall behaviour. ex_eret asserted during EXC -> ignored.
- **Reset:** assert reset during freeze with wcnt=3 -> immediately stalls=0, flushes=1, wcnt=0. On release, the default outputs resume.
